// File: rtl/mesi_isc_sched_pkg.sv
// Shared encodings and FSM state type for the broadcast scheduler.
//   MBUS_* : main-bus command codes from the CPUs
//   CBUS_* : coherence-bus command codes to the CPUs
//   sched_state_e : scheduler FSM states
//   oh2idx : one-hot (4) to index helper
package mesi_isc_sched_pkg;

  localparam int unsigned MBUS_NOP      = 0;
  localparam int unsigned MBUS_WR       = 1;
  localparam int unsigned MBUS_RD       = 2;
  localparam int unsigned MBUS_WR_BROAD = 3;
  localparam int unsigned MBUS_RD_BROAD = 4;

  localparam int unsigned CBUS_NOP      = 0;
  localparam int unsigned CBUS_WR_SNOOP = 1;
  localparam int unsigned CBUS_RD_SNOOP = 2;
  localparam int unsigned CBUS_EN_WR    = 3;
  localparam int unsigned CBUS_EN_RD    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SNOOP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_RESP   = 2'd3
  } sched_state_e;

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mesi_isc_rr_arb.sv
// 4-way round-robin picker; search starts at last_grant+1 (mod 4).
//   req        : request vector
//   last_grant : index of the most recently served requester
//   gnt_c      : one-hot grant (combinational)
//   gnt_vld_c  : some request was granted (combinational)
module mesi_isc_rr_arb (
  input  logic [3:0] req,
  input  logic [1:0] last_grant,
  output logic [3:0] gnt_c,
  output logic       gnt_vld_c
);

  logic [1:0] idx;

  always_comb begin
    gnt_c     = 4'b0000;
    gnt_vld_c = 1'b0;
    idx       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!gnt_vld_c && req[idx]) begin
        gnt_c[idx] = 1'b1;
        gnt_vld_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesi_isc_broad_sched.sv
// Broadcast scheduler: serialises WR_BROAD/RD_BROAD requests from 4 CPUs,
// snoops the three other CPUs, enables the originator, then acks it.
//   clk, rst (sync, active-high)
//   mbus_cmd_array/mbus_addr_array : per-CPU request command and address
//   mbus_ack                       : one-cycle completion pulse per CPU
//   cbus_addr, cbus_cmd0..3        : coherence broadcast address/commands
//   cbus_ack0..3                   : per-CPU coherence acknowledge
//   sched_err                      : watchdog abort pulse
// Optional watchdog: define MESI_ISC_SCHED_TIMEOUT_EN.
module mesi_isc_broad_sched
  import mesi_isc_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MBUS_CMD_WIDTH = 3,
  parameter int unsigned CBUS_CMD_WIDTH = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_array  [3:0],
  input  logic [ADDR_WIDTH-1:0]     mbus_addr_array [3:0],
  output logic [3:0]                mbus_ack,
  output logic [ADDR_WIDTH-1:0]     cbus_addr,
  output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd0,
  output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd1,
  output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd2,
  output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd3,
  input  logic                      cbus_ack0,
  input  logic                      cbus_ack1,
  input  logic                      cbus_ack2,
  input  logic                      cbus_ack3,
  output logic                      sched_err
);

  sched_state_e              state, state_nxt;
  logic [1:0]                orig, orig_nxt, last_grant, last_grant_nxt, gidx;
  logic                      is_wr, is_wr_nxt;
  logic [3:0]                pend, pend_nxt, req, gnt, ack, mbus_ack_nxt;
  logic                      gnt_vld, wd_warn, wd_expire;
  logic [ADDR_WIDTH-1:0]     addr_nxt;
  logic [CBUS_CMD_WIDTH-1:0] cmd_q [4];
  logic [CBUS_CMD_WIDTH-1:0] cmd_nxt [4];

  assign ack       = {cbus_ack3, cbus_ack2, cbus_ack1, cbus_ack0};
  assign cbus_cmd0 = cmd_q[0];
  assign cbus_cmd1 = cmd_q[1];
  assign cbus_cmd2 = cmd_q[2];
  assign cbus_cmd3 = cmd_q[3];

  // Only broadcast commands are requests.
  always_comb begin
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      req[i] = (mbus_cmd_array[i] == MBUS_CMD_WIDTH'(MBUS_WR_BROAD)) ||
               (mbus_cmd_array[i] == MBUS_CMD_WIDTH'(MBUS_RD_BROAD));
    end
  end

  mesi_isc_rr_arb u_arb (
    .req        (req),
    .last_grant (last_grant),
    .gnt_c      (gnt),
    .gnt_vld_c  (gnt_vld)
  );

  assign gidx = oh2idx(gnt);

`ifdef MESI_ISC_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wdog;
  logic            wd_active, wd_stay;
  logic            sched_err_q;

  // Counts cycles spent in SNOOP/ENABLE. sched_err is raised during the
  // final allowed cycle, and that same cycle aborts to IDLE.
  assign wd_active = (state == ST_SNOOP) || (state == ST_ENABLE);
  assign wd_expire = wd_active && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign wd_stay   = (state_nxt == ST_SNOOP) || (state_nxt == ST_ENABLE);
  assign wd_warn   = wd_active && wd_stay && (wdog == WD_W'(TIMEOUT_CYCLES - 2));
  assign sched_err = sched_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog        <= '0;
      sched_err_q <= 1'b0;
    end else begin
      wdog        <= (wd_active && wd_stay) ? wdog + WD_W'(1) : '0;
      sched_err_q <= wd_warn;
    end
  end
`else
  assign wd_warn   = 1'b0;
  assign wd_expire = 1'b0;
  assign sched_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (gnt_vld) state_nxt = ST_SNOOP;
      ST_SNOOP:  if ((pend & ~ack) == 4'b0000) state_nxt = ST_ENABLE;
      ST_ENABLE: if (ack[orig]) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (wd_expire) state_nxt = ST_IDLE;
  end

  // Output/datapath next values; all outputs are registered from these.
  always_comb begin
    orig_nxt       = orig;
    is_wr_nxt      = is_wr;
    addr_nxt       = cbus_addr;
    pend_nxt       = 4'b0000;
    last_grant_nxt = last_grant;
    mbus_ack_nxt   = 4'b0000;
    for (int i = 0; i < 4; i++) cmd_nxt[i] = CBUS_CMD_WIDTH'(CBUS_NOP);

    if ((state == ST_IDLE) && gnt_vld) begin
      orig_nxt  = gidx;
      is_wr_nxt = (mbus_cmd_array[gidx] == MBUS_CMD_WIDTH'(MBUS_WR_BROAD));
      addr_nxt  = mbus_addr_array[gidx];
      pend_nxt  = ~gnt;
    end else if (state == ST_SNOOP) begin
      pend_nxt  = pend & ~ack;
    end

    if ((state == ST_RESP) || wd_expire) last_grant_nxt = orig;

    case (state_nxt)
      ST_SNOOP: begin
        for (int i = 0; i < 4; i++) begin
          if (pend_nxt[i])
            cmd_nxt[i] = is_wr_nxt ? CBUS_CMD_WIDTH'(CBUS_WR_SNOOP)
                                   : CBUS_CMD_WIDTH'(CBUS_RD_SNOOP);
        end
      end
      ST_ENABLE: cmd_nxt[orig_nxt] = is_wr_nxt ? CBUS_CMD_WIDTH'(CBUS_EN_WR)
                                               : CBUS_CMD_WIDTH'(CBUS_EN_RD);
      ST_RESP:   mbus_ack_nxt = 4'b0001 << orig_nxt;
      default:   ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      orig       <= 2'd0;
      is_wr      <= 1'b0;
      pend       <= 4'b0000;
      last_grant <= 2'd3;
      mbus_ack   <= 4'b0000;
      cbus_addr  <= '0;
      for (int i = 0; i < 4; i++) cmd_q[i] <= CBUS_CMD_WIDTH'(CBUS_NOP);
    end else begin
      orig       <= orig_nxt;
      is_wr      <= is_wr_nxt;
      pend       <= pend_nxt;
      last_grant <= last_grant_nxt;
      mbus_ack   <= mbus_ack_nxt;
      cbus_addr  <= addr_nxt;
      for (int i = 0; i < 4; i++) cmd_q[i] <= cmd_nxt[i];
    end
  end

endmodule
